alu_seq_exec: RTL and testbench
===============================

// Module: alu_seq_exec
// PURPOSE
//  Multi-cycle execution unit at the consuming end of the 4-bit ALU operation code produced by the ALU controller.
//  Accepts {operation, src_a, src_b} over a valid/ready handshake and returns the result and branch condition over a second valid/ready handshake.
//  Sits in the execute stage between the operand muxes and writeback/branch logic. Shifts are iterative, one bit per cycle.
// PARAMETERS
//  DATA_W   32  operand/result width; shift amount = src_b[$clog2(DATA_W)-1:0]
// PORTS
//  clk           in   1       system clock, rising edge
//  reset         in   1       synchronous, active-high reset
//  in_valid      in   1       request valid
//  in_ready      out  1       unit can accept request this cycle
//  operation     in   4       ALU operation code (table below)
//  src_a         in   DATA_W  operand A
//  src_b         in   DATA_W  operand B / shift amount / LUI immediate
//  out_valid     out  1       result valid, held until out_ready
//  out_ready     in   1       downstream accepts result
//  result        out  DATA_W  operation result
//  branch_taken  out  1       branch condition true (branch codes only, else 0)
//  illegal_op    out  1       operation code not in table; qualified by out_valid
//  busy          out  1       state != IDLE
// BEHAVIOUR
//  Op codes: 0000 AND, 0001 XOR, 0011 OR, 0100 ADD, 0010 SUB, 1110 SLT (signed),
//   1001 SLL, 1100 SRL, 0111 SRA, 1010 LUI (result=src_b),
//   1000 BEQ, 0110 BNE, 1101 BLT (signed), 0101 BGE (signed); others illegal.
//  Branch codes: result = {DATA_W-1 zeros, taken}, branch_taken = taken. SLT result = {0..,lt}.
//  ADD/SUB wrap modulo 2^DATA_W; no overflow flag. SRA replicates src_a MSB.
//  Illegal code: result=0, branch_taken=0, illegal_op=1, 1-cycle latency.
//  FSM states: IDLE, SHIFT, DONE.
//   IDLE: in_ready=1; on in_valid capture operands. Non-shift or shamt==0 -> DONE; shift with shamt=k>0 -> SHIFT, cnt=k.
//   SHIFT: shift the working register by 1 bit per cycle, cnt--; when cnt==1 the final shift is done and the FSM enters DONE.
//   DONE: out_valid=1, outputs stable. If out_ready: in_ready=1; on in_valid the new op is captured (same rules as IDLE), else -> IDLE.
//  Latency: accept at edge N -> out_valid at N+1 (non-shift, shamt 0); N+1+k (shift by k).
//  Throughput: back-to-back non-shift ops 1/cycle while out_ready=1.
//  out_ready low in DONE: hold result/flags, in_ready=0, no capture.
//  in_valid during SHIFT: ignored (in_ready=0); operands not sampled.
//  Reset (any state, incl. mid-shift): state=IDLE, out_valid=0, result=0, branch_taken=0,
//   illegal_op=0, busy=0, cnt=0; the in-flight op is discarded with no output.
//  in_ready is combinational from state and out_ready; no combinational path from in_valid to in_ready.
// CONFIGURATION
//  ALU_FAST_SHIFT_EN defined: shifts use a single-cycle barrel shifter, SHIFT state unused,
//   all legal ops have 1-cycle latency. Undefined: iterative shift as above.
// TESTING
//  ADD a=7,b=0xFFFFFFFF -> out_valid next cycle, result=6, branch_taken=0.
//  SRA a=0x80000000,b=4 (no FAST) -> busy 4 cycles, out_valid at N+5, result=0xF8000000.
//  BLT a=0xFFFFFFFF,b=1 -> result=1, branch_taken=1; BGE same operands -> 0,0.
//  op=1111 -> illegal_op=1, result=0 at N+1; next legal op clears illegal_op.
//  SLL a=1,b=31, out_ready=0 for 3 cycles after out_valid -> result 0x80000000 held, in_ready=0.
//  reset asserted 2 cycles into SRL by 10 -> next cycle IDLE, out_valid=0, no result emitted.

Source files
------------

// File: rtl/alu_seq_exec.sv
// ---------------------------------------------------------------------------
// alu_seq_exec
//   Multi-cycle execution unit driven by the 4-bit ALU operation code.
//   A request {operation, src_a, src_b} is accepted over an input valid/ready
//   handshake. The result and branch condition are returned over an output
//   valid/ready handshake. Shifts are iterative and move one bit per cycle.
//
//   Handshake rule (both sides): a transfer happens on a rising clk edge where
//   valid and ready are both high. A producer holds valid and its payload
//   until that transfer. in_ready depends only on the state and out_ready.
//
//   Optional feature macro: ALU_FAST_SHIFT_EN
//     defined   -> shifts use a single-cycle barrel shifter; SHIFT is never used
//     undefined -> shifts take one cycle per bit of shift amount
//
// Ports
//   clk, reset     rising-edge clock, synchronous active-high reset
//   in_valid/in_ready, operation, src_a, src_b    request side
//   out_valid/out_ready, result, branch_taken, illegal_op   response side
//   busy           high whenever the FSM is not IDLE
//   dbg_state      current FSM state encoding (0 IDLE, 1 SHIFT, 2 DONE)
// ---------------------------------------------------------------------------
module alu_seq_exec #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        operation,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              branch_taken,
    output logic              illegal_op,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int SH_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SK_SLL = 2'd0,
        SK_SRL = 2'd1,
        SK_SRA = 2'd2
    } shift_t;

    state_t            state_q, state_d;
    shift_t            shk_q, shk_d;
    logic [SH_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              branch_q, branch_d;
    logic              illegal_q, illegal_d;

    logic [SH_W-1:0]   shamt;
    logic              eq, lt;
    logic [DATA_W-1:0] step;

    assign shamt = src_b[SH_W-1:0];
    assign eq    = (src_a == src_b);
    assign lt    = ($signed(src_a) < $signed(src_b));

    // One-bit step of the iterative shifter; result_q doubles as the working
    // register while in SHIFT (out_valid is low, so the partial value is unseen).
    always_comb begin
        case (shk_q)
            SK_SLL:  step = {result_q[DATA_W-2:0], 1'b0};
            SK_SRL:  step = {1'b0, result_q[DATA_W-1:1]};
            default: step = {result_q[DATA_W-1], result_q[DATA_W-1:1]};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        shk_d     = shk_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        branch_d  = branch_q;
        illegal_d = illegal_q;

        in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);

        case (state_q)
            S_SHIFT: begin
                result_d = step;
                cnt_d    = cnt_q - 1'b1;
                // cnt==1 means this step is the last one.
                if (cnt_q == SH_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        // A capture overrides the DONE->IDLE drain so ops can stream 1/cycle.
        if (in_valid && in_ready) begin
            state_d   = S_DONE;
            result_d  = '0;
            branch_d  = 1'b0;
            illegal_d = 1'b0;
            case (operation)
                4'b0000: result_d = src_a & src_b;
                4'b0001: result_d = src_a ^ src_b;
                4'b0011: result_d = src_a | src_b;
                4'b0100: result_d = src_a + src_b;
                4'b0010: result_d = src_a - src_b;
                4'b1110: result_d = {{(DATA_W-1){1'b0}}, lt};
                4'b1010: result_d = src_b;
                4'b1000: begin
                    branch_d = eq;
                    result_d = {{(DATA_W-1){1'b0}}, eq};
                end
                4'b0110: begin
                    branch_d = !eq;
                    result_d = {{(DATA_W-1){1'b0}}, !eq};
                end
                4'b1101: begin
                    branch_d = lt;
                    result_d = {{(DATA_W-1){1'b0}}, lt};
                end
                4'b0101: begin
                    branch_d = !lt;
                    result_d = {{(DATA_W-1){1'b0}}, !lt};
                end
                4'b1001, 4'b1100, 4'b0111: begin
`ifdef ALU_FAST_SHIFT_EN
                    case (operation)
                        4'b1001: result_d = src_a << shamt;
                        4'b1100: result_d = src_a >> shamt;
                        default: result_d = DATA_W'($signed(src_a) >>> shamt);
                    endcase
`else
                    result_d = src_a;
                    if (shamt != '0) begin
                        state_d = S_SHIFT;
                        cnt_d   = shamt;
                        case (operation)
                            4'b1001: shk_d = SK_SLL;
                            4'b1100: shk_d = SK_SRL;
                            default: shk_d = SK_SRA;
                        endcase
                    end
`endif
                end
                default: illegal_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shk_q     <= SK_SLL;
            cnt_q     <= '0;
            result_q  <= '0;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shk_q     <= shk_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            branch_q  <= branch_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid    = (state_q == S_DONE);
    assign result       = result_q;
    assign branch_taken = branch_q;
    assign illegal_op   = illegal_q;
    assign busy         = (state_q != S_IDLE);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_exec
//   Directed bench for alu_seq_exec (DATA_W = 32). Inputs change 1 time unit
//   after the rising edge; everything is sampled on the falling edge. The
//   driver pushes the hand-computed response into exp_q when a request is
//   accepted; the monitor pops and compares on every output transfer.
// ---------------------------------------------------------------------------
module tb_alu_seq_exec;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    operation;
    logic [DW-1:0] src_a;
    logic [DW-1:0] src_b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;
    logic          branch_taken;
    logic          illegal_op;
    logic          busy;
    logic [1:0]    dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic [DW+1:0] exp_q[$];
    logic [DW+1:0] mon_exp;

    alu_seq_exec #(.DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .operation    (operation),
        .src_a        (src_a),
        .src_b        (src_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .branch_taken (branch_taken),
        .illegal_op   (illegal_op),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every output transfer must match the oldest entry.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got result %h, no response expected", result);
            end else begin
                mon_exp = exp_q.pop_front();
                check("sb_result",  result,            mon_exp[DW+1:2]);
                check("sb_branch",  DW'(branch_taken), DW'(mon_exp[1]));
                check("sb_illegal", DW'(illegal_op),   DW'(mon_exp[0]));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] er, input logic eb, input logic ei,
                        input bit push, output int waits);
        bit ok;
        operation = op;
        src_a     = a;
        src_b     = b;
        in_valid  = 1'b1;
        waits     = 0;
        ok        = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            waits++;
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: op %b never accepted", op);
        end else if (push) begin
            exp_q.push_back({er, eb, ei});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 999;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int lat;
        reset     = 1'b1;
        in_valid  = 1'b0;
        operation = 4'b0000;
        src_a     = '0;
        src_b     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        check("rst_in_ready",  DW'(in_ready),     DW'(1));
        check("rst_out_valid", DW'(out_valid),    DW'(0));
        check("rst_busy",      DW'(busy),         DW'(0));
        check("rst_result",    result,            32'h0);
        check("rst_branch",    DW'(branch_taken), DW'(0));
        check("rst_illegal",   DW'(illegal_op),   DW'(0));
        @(posedge clk);
        #1;

        // ADD wraps: 7 + 0xFFFFFFFF = 6, one-cycle latency
        send(4'b0100, 32'd7, 32'hFFFF_FFFF, 32'd6, 1'b0, 1'b0, 1'b1, w);
        wait_valid(lat);
        check("add_latency", DW'(lat), DW'(1));
        @(posedge clk);
        #1;

        // SRA by 4: busy in SHIFT for 4 cycles, then DONE
        send(4'b0111, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 1'b1, w);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("sra_busy",      DW'(busy),      DW'(1));
            check("sra_not_valid", DW'(out_valid), DW'(0));
        end
        @(negedge clk);
        check("sra_valid", DW'(out_valid), DW'(1));
        @(posedge clk);
        #1;

        // Back-to-back non-shift ops: each must be accepted on the first cycle
        send(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b1, w);
        check("b2b_and_wait", DW'(w), DW'(1));
        send(4'b0001, 32'h1234_5678, 32'hFFFF_0000, 32'hEDCB_5678, 1'b0, 1'b0, 1'b1, w);
        check("b2b_xor_wait", DW'(w), DW'(1));
        send(4'b0011, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 1'b0, 1'b1, w);
        check("b2b_or_wait", DW'(w), DW'(1));
        send(4'b0010, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, w);
        check("b2b_sub_wait", DW'(w), DW'(1));
        send(4'b1110, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1, w);
        send(4'b1110, 32'd5, 32'd3, 32'd0, 1'b0, 1'b0, 1'b1, w);
        send(4'b1010, 32'h1111_1111, 32'hABCD_E000, 32'hABCD_E000, 1'b0, 1'b0, 1'b1, w);
        send(4'b1000, 32'd5, 32'd5, 32'd1, 1'b1, 1'b0, 1'b1, w);
        send(4'b0110, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 1'b1, w);
        send(4'b1101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 1'b0, 1'b1, w);
        send(4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, w);
        check("b2b_bge_wait", DW'(w), DW'(1));

        // Illegal codes, and a legal op between them clears illegal_op
        send(4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 1'b0, 1'b1, 1'b1, w);
        wait_valid(lat);
        check("illegal_latency", DW'(lat), DW'(1));
        @(posedge clk);
        #1;
        send(4'b0100, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b1, w);
        send(4'b1011, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 1'b1, w);

        // Shift amount 0 completes in one cycle; only low 5 bits of src_b count
        send(4'b1001, 32'd3, 32'd0, 32'd3, 1'b0, 1'b0, 1'b1, w);
        wait_valid(lat);
        check("sll0_latency", DW'(lat), DW'(1));
        @(posedge clk);
        #1;
        send(4'b1100, 32'h8000_0000, 32'h0000_0025, 32'h0400_0000, 1'b0, 1'b0, 1'b1, w);
        wait_valid(lat);
        check("srl5_latency", DW'(lat), DW'(6));
        @(posedge clk);
        #1;

        // SLL by 31 with out_ready low: result held, no new request accepted
        out_ready = 1'b0;
        send(4'b1001, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b1, w);
        wait_valid(lat);
        check("sll31_latency", DW'(lat), DW'(32));
        operation = 4'b0100;
        src_a     = 32'd100;
        src_b     = 32'd200;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid",    DW'(out_valid), DW'(1));
            check("hold_result",   result,         32'h8000_0000);
            check("hold_in_ready", DW'(in_ready),  DW'(0));
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset two cycles into a 10-bit SRL: op is dropped silently
        send(4'b1100, 32'h1234_5678, 32'd10, 32'd0, 1'b0, 1'b0, 1'b0, w);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_state",     DW'(dbg_state),    DW'(0));
        check("mid_rst_out_valid", DW'(out_valid),    DW'(0));
        check("mid_rst_busy",      DW'(busy),         DW'(0));
        check("mid_rst_result",    result,            32'h0);
        check("mid_rst_in_ready",  DW'(in_ready),     DW'(1));
        repeat (15) @(negedge clk);
        @(posedge clk);
        #1;

        send(4'b0001, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, w);

        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_queue_empty", DW'(exp_q.size()), DW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
